// File: rtl/img_pkg.sv
// Shared types and helpers for the frame buffer and the pixel kernels.
package img_pkg;

   // Frame buffer load state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_READY = 2'd2
   } fb_state_e;

   // Offset of window tap 'idx' from the window centre (window size 'win' is odd).
   function automatic int tap_off(input int idx, input int win);
      return idx - (win / 2);
   endfunction

   // Flattened tap index of tap [j][i] in a window 'win_wd' taps wide.
   function automatic int flat_idx(input int j, input int i, input int win_wd);
      return (j * win_wd) + i;
   endfunction

endpackage

// File: rtl/win_tap_sel.sv
// Combinational window extraction: bounds check, zero padding and flattening.
module win_tap_sel
   import img_pkg::*;
#(
   parameter int IMG_WD     = 16,
   parameter int IMG_HT     = 16,
   parameter int COORD_BITS = 4,
   parameter int WIN_WD     = 3,
   parameter int WIN_HT     = 3,
   parameter int PXL_BITS   = 12,
   parameter int ADDR_BITS  = $clog2(IMG_WD * IMG_HT)
) (
   input  logic                               rd_en,
   input  logic [COORD_BITS-1:0]              rd_x,
   input  logic [COORD_BITS-1:0]              rd_y,
   input  logic [PXL_BITS-1:0]                mem_pix [IMG_WD*IMG_HT],
   output logic [WIN_HT*WIN_WD*PXL_BITS-1:0]  rd_data_flat
);

   int ty;
   int tx;

   // Gather each tap; taps outside the image (or a disabled read) read as zero.
   always_comb begin
      rd_data_flat = '0;
      ty = 0;
      tx = 0;
      for (int j = 0; j < WIN_HT; j++) begin
         for (int i = 0; i < WIN_WD; i++) begin
            ty = int'(rd_y) + tap_off(j, WIN_HT);
            tx = int'(rd_x) + tap_off(i, WIN_WD);
            if (rd_en && (ty >= 0) && (ty < IMG_HT) && (tx >= 0) && (tx < IMG_WD)) begin
               rd_data_flat[flat_idx(j, i, WIN_WD)*PXL_BITS +: PXL_BITS] =
                  mem_pix[ADDR_BITS'((ty * IMG_WD) + tx)];
            end
         end
      end
   end

endmodule

// File: rtl/win_frame_buf.sv
// Frame buffer: window reads, single-pixel writes and raster-order frame load.
module win_frame_buf
   import img_pkg::*;
#(
   parameter int IMG_WD     = 16,
   parameter int IMG_HT     = 16,
   parameter int COORD_BITS = 4,
   parameter int WIN_WD     = 3,
   parameter int WIN_HT     = 3,
   parameter int PXL_BITS   = 12
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               rd_en,
   input  logic [COORD_BITS-1:0]              rd_x,
   input  logic [COORD_BITS-1:0]              rd_y,
   output logic [WIN_HT*WIN_WD*PXL_BITS-1:0]  rd_data_flat,
   input  logic                               wr_en,
   input  logic [COORD_BITS-1:0]              wr_x,
   input  logic [COORD_BITS-1:0]              wr_y,
   input  logic signed [PXL_BITS-1:0]         wr_data_pxl,
   input  logic                               ld_start,
   input  logic                               ld_valid,
   output logic                               ld_ready,
   input  logic signed [PXL_BITS-1:0]         ld_data,
   output logic                               ld_done,
   output logic                               frame_vld,
   output fb_state_e                          dbg_state
);

   localparam int ADDR_BITS = $clog2(IMG_WD * IMG_HT);

   // Load stream handshake: a pixel transfers on a rising clk edge where
   // ld_valid & ld_ready are both high; ld_data must be stable while ld_valid
   // is high and ready is low. ld_ready never depends on ld_valid.

   logic [PXL_BITS-1:0]   mem [IMG_WD*IMG_HT];
   fb_state_e             state;
   logic [COORD_BITS-1:0] ld_x;
   logic [COORD_BITS-1:0] ld_y;
   logic                  ld_acc;
   logic                  ld_last;
   logic                  wr_in_range;
   logic [ADDR_BITS-1:0]  wr_addr;
   logic [ADDR_BITS-1:0]  ld_addr;

   // Handshake, address and status decode.
   always_comb begin
      ld_ready    = (state == ST_LOAD) && !wr_en && !ld_start;
      ld_acc      = ld_valid && ld_ready;
      ld_last     = (int'(ld_x) == IMG_WD - 1) && (int'(ld_y) == IMG_HT - 1);
      ld_done     = ld_acc && ld_last;
      frame_vld   = (state == ST_READY);
      wr_in_range = (int'(wr_x) < IMG_WD) && (int'(wr_y) < IMG_HT);
      wr_addr     = ADDR_BITS'((int'(wr_y) * IMG_WD) + int'(wr_x));
      ld_addr     = ADDR_BITS'((int'(ld_y) * IMG_WD) + int'(ld_x));
      dbg_state   = state;
   end

   // Pixel storage: kernel writes win over the stream (the stream stalls instead).
   always_ff @(posedge clk) begin
      if (wr_en && wr_in_range) begin
         mem[wr_addr] <= wr_data_pxl;
      end else if (ld_acc) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Load FSM and raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         ld_x  <= '0;
         ld_y  <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_READY: begin
               if (ld_start) begin
                  state <= ST_LOAD;
                  ld_x  <= '0;
                  ld_y  <= '0;
               end
            end
            ST_LOAD: begin
               if (ld_start) begin
                  ld_x <= '0;
                  ld_y <= '0;
               end else if (ld_acc) begin
                  if (ld_last) begin
                     state <= ST_READY;
                     ld_x  <= '0;
                     ld_y  <= '0;
                  end else if (int'(ld_x) == IMG_WD - 1) begin
                     ld_x <= '0;
                     ld_y <= ld_y + COORD_BITS'(1);
                  end else begin
                     ld_x <= ld_x + COORD_BITS'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   win_tap_sel #(
      .IMG_WD     (IMG_WD),
      .IMG_HT     (IMG_HT),
      .COORD_BITS (COORD_BITS),
      .WIN_WD     (WIN_WD),
      .WIN_HT     (WIN_HT),
      .PXL_BITS   (PXL_BITS),
      .ADDR_BITS  (ADDR_BITS)
   ) u_tap_sel (
      .rd_en        (rd_en),
      .rd_x         (rd_x),
      .rd_y         (rd_y),
      .mem_pix      (mem),
      .rd_data_flat (rd_data_flat)
   );

endmodule

// File: tb/tb_win_frame_buf.sv
// Directed testbench for win_frame_buf (5-bit coordinates to reach x=16).
module tb_win_frame_buf;
   import img_pkg::*;

   localparam int IMG_WD = 16;
   localparam int IMG_HT = 16;
   localparam int CB     = 5;
   localparam int WW     = 3;
   localparam int WH     = 3;
   localparam int PB     = 12;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   rd_en = 1'b0;
   logic [CB-1:0]          rd_x = '0;
   logic [CB-1:0]          rd_y = '0;
   logic [WH*WW*PB-1:0]    rd_data_flat;
   logic                   wr_en = 1'b0;
   logic [CB-1:0]          wr_x = '0;
   logic [CB-1:0]          wr_y = '0;
   logic signed [PB-1:0]   wr_data_pxl = '0;
   logic                   ld_start = 1'b0;
   logic                   ld_valid = 1'b0;
   logic                   ld_ready;
   logic signed [PB-1:0]   ld_data = '0;
   logic                   ld_done;
   logic                   frame_vld;
   fb_state_e              dbg_state;

   int checks   = 0;
   int failures = 0;

   // clock
   always #5 clk = ~clk;

   win_frame_buf #(
      .IMG_WD(IMG_WD), .IMG_HT(IMG_HT), .COORD_BITS(CB),
      .WIN_WD(WW), .WIN_HT(WH), .PXL_BITS(PB)
   ) dut (
      .clk(clk), .rst(rst),
      .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y), .rd_data_flat(rd_data_flat),
      .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data_pxl(wr_data_pxl),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_data(ld_data), .ld_done(ld_done), .frame_vld(frame_vld),
      .dbg_state(dbg_state)
   );

   function automatic logic [31:0] px(input int v);
      logic [31:0] t;
      t = v;
      return {20'd0, t[PB-1:0]};
   endfunction

   function automatic logic [31:0] tap(input int j, input int i);
      return {20'd0, rd_data_flat[(j*WW+i)*PB +: PB]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_center(input int x, input int y, output logic [31:0] v);
      rd_en = 1'b1;
      rd_x  = CB'(x);
      rd_y  = CB'(y);
      #1;
      v = tap(1, 1);
   endtask

   function automatic int val2(input int p);
      return 2 * p + 100;
   endfunction

   initial begin
      logic [31:0] v;
      int p;
      int stall_cnt;

      // 1. reset, then full load with value y*16+x
      tick();
      tick();
      chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rst_ready", 32'(ld_ready), 32'd0);
      chk("rst_done", 32'(ld_done), 32'd0);
      chk("rst_fvld", 32'(frame_vld), 32'd0);
      rst = 1'b0;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      chk("load_state", 32'(dbg_state), 32'(ST_LOAD));
      for (int q = 0; q < 256; q++) begin
         ld_valid = 1'b1;
         ld_data  = PB'(q);
         #1;
         if (q == 0) chk("first_ready", 32'(ld_ready), 32'd1);
         if (q == 0) chk("done_early", 32'(ld_done), 32'd0);
         if (q == 255) chk("done_last", 32'(ld_done), 32'd1);
         tick();
      end
      ld_valid = 1'b0;
      #1;
      chk("fvld_after_load", 32'(frame_vld), 32'd1);
      chk("done_cleared", 32'(ld_done), 32'd0);
      chk("ready_state", 32'(dbg_state), 32'(ST_READY));

      // 2. interior window at (5,5)
      rd_en = 1'b1; rd_x = 5; rd_y = 5;
      #1;
      chk("w55_00", tap(0, 0), px(68));
      chk("w55_01", tap(0, 1), px(69));
      chk("w55_02", tap(0, 2), px(70));
      chk("w55_10", tap(1, 0), px(84));
      chk("w55_11", tap(1, 1), px(85));
      chk("w55_12", tap(1, 2), px(86));
      chk("w55_20", tap(2, 0), px(100));
      chk("w55_21", tap(2, 1), px(101));
      chk("w55_22", tap(2, 2), px(102));

      // 3. corners with zero padding
      rd_x = 0; rd_y = 0;
      #1;
      chk("w00_00", tap(0, 0), px(0));
      chk("w00_01", tap(0, 1), px(0));
      chk("w00_02", tap(0, 2), px(0));
      chk("w00_10", tap(1, 0), px(0));
      chk("w00_20", tap(2, 0), px(0));
      chk("w00_11", tap(1, 1), px(0));
      chk("w00_12", tap(1, 2), px(1));
      chk("w00_21", tap(2, 1), px(16));
      chk("w00_22", tap(2, 2), px(17));
      rd_x = 15; rd_y = 15;
      #1;
      chk("wff_00", tap(0, 0), px(238));
      chk("wff_01", tap(0, 1), px(239));
      chk("wff_10", tap(1, 0), px(254));
      chk("wff_11", tap(1, 1), px(255));
      chk("wff_02", tap(0, 2), px(0));
      chk("wff_12", tap(1, 2), px(0));
      chk("wff_20", tap(2, 0), px(0));
      chk("wff_21", tap(2, 1), px(0));
      chk("wff_22", tap(2, 2), px(0));
      rd_en = 1'b0;
      #1;
      chk("rd_dis_zero", 32'(rd_data_flat == '0), 32'd1);

      // 4. read-during-write returns old value; out-of-range write ignored
      rd_en = 1'b1; rd_x = 3; rd_y = 2;
      wr_en = 1'b1; wr_x = 3; wr_y = 2; wr_data_pxl = -12'sd7;
      #1;
      chk("rdw_old", tap(1, 1), px(35));
      tick();
      wr_en = 1'b0;
      #1;
      chk("rdw_new", tap(1, 1), px(-7));
      chk("fvld_after_wr", 32'(frame_vld), 32'd1);
      wr_en = 1'b1; wr_x = 16; wr_y = 0; wr_data_pxl = 12'sd999;
      tick();
      wr_en = 1'b0;
      read_center(0, 1, v);
      chk("oob_wr_01", v, px(16));
      read_center(15, 0, v);
      chk("oob_wr_150", v, px(15));

      // 5. reload with wr_en stalls mid-stream
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      #1;
      chk("reload_fvld", 32'(frame_vld), 32'd0);
      p = 0;
      stall_cnt = 0;
      for (int c = 0; c < 400 && p < 256; c++) begin
         ld_valid = 1'b1;
         ld_data  = PB'(val2(p));
         if (p == 100 && stall_cnt < 3) begin
            wr_en = 1'b1; wr_x = 0; wr_y = 15; wr_data_pxl = 12'sd5;
         end else begin
            wr_en = 1'b0;
         end
         #1;
         if (wr_en) begin
            chk("stall_ready", 32'(ld_ready), 32'd0);
            stall_cnt++;
         end
         if (p == 255 && ld_ready) chk("done_reload", 32'(ld_done), 32'd1);
         if (ld_ready) begin
            tick();
            p++;
         end else begin
            tick();
         end
      end
      ld_valid = 1'b0;
      wr_en = 1'b0;
      chk("reload_count", 32'(p), 32'd256);
      chk("stall_cycles", 32'(stall_cnt), 32'd3);
      #1;
      chk("reload_fvld1", 32'(frame_vld), 32'd1);
      for (int y = 0; y < IMG_HT; y++) begin
         for (int x = 0; x < IMG_WD; x++) begin
            read_center(x, y, v);
            chk("reload_pix", v, px(val2(y * 16 + x)));
         end
      end

      // 6. reset mid-load, then start/valid collisions
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int q = 0; q < 40; q++) begin
         ld_valid = 1'b1;
         ld_data  = PB'(-q - 1);
         tick();
      end
      ld_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ld_valid = 1'b1;
      ld_data = 12'sd77;
      #1;
      chk("rst_mid_state", 32'(dbg_state), 32'(ST_IDLE));
      chk("rst_mid_fvld", 32'(frame_vld), 32'd0);
      chk("rst_mid_ready", 32'(ld_ready), 32'd0);
      tick();
      chk("idle_fvld", 32'(frame_vld), 32'd0);
      read_center(0, 0, v);
      chk("kept_p0", v, px(-1));
      read_center(7, 2, v);
      chk("kept_p39", v, px(-40));
      read_center(8, 2, v);
      chk("kept_p40", v, px(val2(40)));
      ld_valid = 1'b1;
      ld_data  = 12'sd1234;
      ld_start = 1'b1;
      #1;
      chk("start_idle_ready", 32'(ld_ready), 32'd0);
      tick();
      ld_start = 1'b0;
      for (int q = 0; q < 5; q++) begin
         ld_valid = 1'b1;
         ld_data  = PB'(600 + q);
         tick();
      end
      ld_data  = 12'sd1234;
      ld_start = 1'b1;
      #1;
      chk("start_load_ready", 32'(ld_ready), 32'd0);
      tick();
      ld_start = 1'b0;
      ld_data  = 12'sd555;
      #1;
      chk("restart_ready", 32'(ld_ready), 32'd1);
      tick();
      ld_valid = 1'b0;
      read_center(0, 0, v);
      chk("restart_p0", v, px(555));
      read_center(1, 0, v);
      chk("restart_p1", v, px(601));
      read_center(5, 0, v);
      chk("restart_p5", v, px(-6));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
